uart_ifmap_loader: RTL and testbench

Upstream stage of the CNN accelerator in the UART build. Receives a serial 8N1 byte stream on the board RX pin and packs 784 bytes (one 28x28 signed 8-bit ifmap) into the ifmap buffer through a write port. Signals frame completion to the accelerator and holds off until the accelerator acknowledges, so each inference sees exactly one clean frame.

---
 rtl/uart_loader_pkg.sv | 16 +
 rtl/uart_rx_core.sv | 124 ++++++++++++
 rtl/uart_ifmap_loader.sv | 101 ++++++++++
 tb/tb_uart_ifmap_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART ifmap loader.
// Build option: define RX_PARITY_EN for 8E1 framing (default 8N1).
package uart_loader_pkg;

    localparam int IFMAP_SIZE_DEF = 784;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: RX synchronizer, bit-timing FSM and shift register.
// Build option: RX_PARITY_EN inserts an even-parity bit check before STOP.
module uart_rx_core
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1085,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_pin_in,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);

    rx_state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_err_q, par_err_d;
    logic                   rx_s;
    logic                   bit_tick;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign bit_tick  = (clk_cnt_q == FULL_LAST);
    assign byte_data = shift_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d     = state_q;
        sync_d      = {sync_q[SYNC_STAGES-2:0], rx_pin_in};
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;
        byte_valid  = 1'b0;
        frame_error = 1'b0;

        case (state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                par_err_d = 1'b0;
                if (!rx_s) state_d = RX_START;
            end
            RX_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (bit_tick) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_cnt_q] = rx_s;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef RX_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`ifdef RX_PARITY_EN
            RX_PARITY: begin
                if (bit_tick) begin
                    clk_cnt_d = '0;
                    par_err_d = (rx_s != ^shift_q);
                    state_d   = RX_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                // Return to IDLE on the sample itself so a back-to-back start bit is not missed.
                if (bit_tick) begin
                    state_d     = RX_IDLE;
                    byte_valid  = rx_s & ~par_err_q;
                    frame_error = ~rx_s | par_err_q;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Synchronizer resets to the idle-high line level so reset release never looks like a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= RX_IDLE;
            sync_q    <= '1;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            state_q   <= state_d;
            sync_q    <= sync_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
        end
    end

endmodule

// File: rtl/uart_ifmap_loader.sv
// Packs received UART bytes into the ifmap buffer and handshakes full frames.
// Build option: RX_PARITY_EN selects 8E1 framing in the receiver.
module uart_ifmap_loader
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1085,
    parameter int IFMAP_SIZE   = IFMAP_SIZE_DEF,
    parameter int ADDR_W       = 10,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_pin_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_valid,
    input  logic              frame_ack,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IFMAP_SIZE - 1);

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              frame_error;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              frame_valid_q, frame_valid_d;
    logic              frame_err_q, frame_err_d;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_rx (
        .clock       (clock),
        .reset       (reset),
        .rx_pin_in   (rx_pin_in),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_error (frame_error)
    );

    always_comb begin
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        count_d       = count_q;
        frame_valid_d = frame_valid_q;
        frame_err_d   = frame_err_q;

        if (byte_valid) begin
            if (frame_valid_q) begin
                frame_err_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = count_q;
                wr_data_d = byte_data;
                count_d   = (count_q == LAST_ADDR) ? '0 : count_q + 1'b1;
            end
        end

        if (frame_error) frame_err_d = 1'b1;

        if (wr_en_q && wr_addr_q == LAST_ADDR) frame_valid_d = 1'b1;

        // Ack is evaluated last so it overrides any same-cycle overrun flag.
        if (frame_ack && frame_valid_q) begin
            frame_valid_d = 1'b0;
            frame_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            count_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            count_q       <= count_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_ifmap_loader.sv
// Scoreboard bench for uart_ifmap_loader: a frame-level model queues expected writes,
// a negedge monitor pops and compares each wr_en pulse.
module tb_uart_ifmap_loader;

    localparam int CPB = 4;
    localparam int FS  = 784;
    localparam int AW  = 10;
    localparam int SS  = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          rx_pin_in = 1'b1;
    logic          frame_ack = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          frame_valid;
    logic          frame_err;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  model_cnt = 0;
    bit  model_fv  = 1'b0;
    bit  model_err = 1'b0;
    bit  fv_pending = 1'b0;

    always #5 clock = ~clock;

    uart_ifmap_loader #(
        .CLKS_PER_BIT (CPB),
        .IFMAP_SIZE   (FS),
        .ADDR_W       (AW),
        .SYNC_STAGES  (SS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_pin_in   (rx_pin_in),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_err   (frame_err)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        rx_pin_in = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx_pin_in = d[i];
            repeat (CPB) tick();
        end
`ifdef RX_PARITY_EN
        rx_pin_in = ^d;
        repeat (CPB) tick();
`endif
        rx_pin_in = stop_bit;
        repeat (CPB) tick();
        rx_pin_in = 1'b1;
        repeat (3) tick();
    endtask

    // Reference model: a good byte is written at the running count unless a frame is pending.
    task automatic send_good(input logic [7:0] d);
        if (!model_fv) begin
            exp_q.push_back('{addr: model_cnt, data: int'(d)});
            model_cnt++;
            if (model_cnt == FS) begin
                model_cnt = 0;
                model_fv  = 1'b1;
            end
        end else begin
            model_err = 1'b1;
        end
        send_byte(d, 1'b1);
    endtask

    task automatic do_ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        if (model_fv) begin
            model_fv  = 1'b0;
            model_err = 1'b0;
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_frame_valid"}, int'(frame_valid), int'(model_fv));
        check({tag, "_frame_err"}, int'(frame_err), int'(model_err));
    endtask

    always @(negedge clock) begin
        if (fv_pending) begin
            check("frame_valid_rise", int'(frame_valid), 1);
            fv_pending = 1'b0;
        end
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr_en", int'(wr_en), 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", int'(wr_addr), e.addr);
                check("wr_data", int'(wr_data), e.data);
                check("frame_valid_low_at_write", int'(frame_valid), 0);
                if (int'(wr_addr) == FS - 1) fv_pending = 1'b1;
            end
        end
    end

    initial begin
        repeat (4) tick();
        check("reset_wr_en", int'(wr_en), 0);
        check("reset_wr_addr", int'(wr_addr), 0);
        check("reset_wr_data", int'(wr_data), 0);
        check_flags("reset");
        reset = 1'b1;
        repeat (4) tick();

        send_good(8'hA5);
        check_flags("single_a5");

        rx_pin_in = 1'b0;
        repeat (CPB / 4) tick();
        rx_pin_in = 1'b1;
        repeat (3 * CPB) tick();
        check_flags("glitch");

        send_byte(8'h3C, 1'b0);
        model_err = 1'b1;
        repeat (3 * CPB) tick();
        check_flags("stop_err");

        do_ack();
        tick();
        check_flags("ack_ignored");

        while (!model_fv) send_good(8'(model_cnt % 256));
        check_flags("frame_full");

        send_good(8'h11);
        check_flags("overrun");

        do_ack();
        check_flags("ack_clear");

        send_good(8'($urandom));
        for (int i = 0; i < 99; i++) send_good(8'($urandom_range(255)));
        check_flags("partial_frame");
        check("queue_drained", exp_q.size(), 0);

        reset = 1'b0;
        repeat (3) tick();
        check("midframe_reset_wr_en", int'(wr_en), 0);
        check("midframe_reset_wr_addr", int'(wr_addr), 0);
        model_cnt = 0;
        model_fv  = 1'b0;
        model_err = 1'b0;
        check_flags("midframe_reset");
        reset = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < FS; i++) begin
            if (i == FS - 1) check_flags("before_last_byte");
            send_good(8'($urandom));
        end
        check_flags("second_frame");
        do_ack();
        check_flags("second_ack");

        repeat (5) tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
